// File: rtl/bp_update_sched_pkg.sv
// Shared definitions for the branch-predictor update scheduler: width/value
// defaults, boolean and write-mode constants, and the scheduler state type.
package bp_update_sched_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int unsigned DEF_TAG_W    = 8;
  localparam logic [1:0]  DEF_INIT_VAL = 2'b11;

  localparam logic MODE_UPDATE = 1'b0;
  localparam logic MODE_FORCE  = 1'b1;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

endpackage

// File: rtl/bp_update_sched_if.sv
// ROB commit, clear request and predictor write port of the update scheduler.
interface bp_update_sched_if
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned TAG_W = DEF_TAG_W
);

  logic             in_rob_valid;
  logic [TAG_W-1:0] in_rob_tag;
  logic             in_rob_jump_res;
  logic             out_rob_full;

  logic             in_clear_req;
  logic             out_clear_busy;

  logic             out_bp_valid;
  logic [TAG_W-1:0] out_bp_tag;
  logic             out_bp_mode;
  logic             out_bp_jump_res;
  logic [1:0]       out_bp_val;

  modport master (
    output in_rob_valid, in_rob_tag, in_rob_jump_res, in_clear_req,
    input  out_rob_full, out_clear_busy,
    input  out_bp_valid, out_bp_tag, out_bp_mode, out_bp_jump_res, out_bp_val
  );

  modport slave (
    input  in_rob_valid, in_rob_tag, in_rob_jump_res, in_clear_req,
    output out_rob_full, out_clear_busy,
    output out_bp_valid, out_bp_tag, out_bp_mode, out_bp_jump_res, out_bp_val
  );

endinterface

// File: rtl/bp_update_sched_fifo.sv
// Update FIFO between ROB commit and predictor write: push/pop/flush with
// registered occupancy; all activity gated by the global enable.
module bp_upd_fifo
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = DEF_TAG_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = en && push && !full && !flush;
  assign do_pop  = en && pop && !empty && !flush;
  assign dout    = mem[head];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (en && flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      if (do_push && !do_pop) begin
        cnt <= cnt + (AW+1)'(1);
      end else if (!do_push && do_pop) begin
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/bp_update_sched.sv
// Schedules predictor-table writes: drains committed branch outcomes in order,
// or sweeps every entry to INIT_VAL on a clear request.
module bp_update_sched
  import bp_update_sched_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TAG_W    = DEF_TAG_W,
  parameter logic [1:0]  INIT_VAL = DEF_INIT_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  bp_update_sched_if.slave bus
);

  state_t           state, state_n;
  logic [TAG_W-1:0] idx, idx_n;
  logic             pop, flush;
  logic             fifo_full, fifo_empty;
  logic [TAG_W:0]   fifo_dout;

  logic             valid_q, valid_n;
  logic [TAG_W-1:0] tag_q, tag_n;
  logic             mode_q, mode_n;
  logic             jr_q, jr_n;
  logic [1:0]       val_q, val_n;

  bp_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .push  (bus.in_rob_valid),
    .pop   (pop),
    .flush (flush),
    .din   ({bus.in_rob_tag, bus.in_rob_jump_res}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Payload registers hold between writes; only valid is forced low each idle cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    pop     = FALSE;
    flush   = FALSE;
    valid_n = FALSE;
    tag_n   = tag_q;
    mode_n  = mode_q;
    jr_n    = jr_q;
    val_n   = val_q;
    if (rdy) begin
      unique case (state)
        IDLE: begin
          if (bus.in_clear_req) begin
            state_n = SWEEP;
            flush   = TRUE;
            idx_n   = '0;
          end else if (!fifo_empty) begin
            pop     = TRUE;
            valid_n = TRUE;
            tag_n   = fifo_dout[TAG_W:1];
            mode_n  = MODE_UPDATE;
            jr_n    = fifo_dout[0];
          end
        end
        SWEEP: begin
          valid_n = TRUE;
          tag_n   = idx;
          mode_n  = MODE_FORCE;
          val_n   = INIT_VAL;
          idx_n   = idx + TAG_W'(1);
          if (idx == '1) begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      valid_q <= 1'b0;
      tag_q   <= '0;
      mode_q  <= 1'b0;
      jr_q    <= 1'b0;
      val_q   <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      valid_q <= valid_n;
      tag_q   <= tag_n;
      mode_q  <= mode_n;
      jr_q    <= jr_n;
      val_q   <= val_n;
    end
  end

  assign bus.out_rob_full    = fifo_full;
  assign bus.out_clear_busy  = (state == SWEEP);
  assign bus.out_bp_valid    = valid_q;
  assign bus.out_bp_tag      = tag_q;
  assign bus.out_bp_mode     = mode_q;
  assign bus.out_bp_jump_res = jr_q;
  assign bus.out_bp_val      = val_q;

endmodule

// File: tb/tb_bp_update_sched.sv
// Scoreboard bench for bp_update_sched: a queue-level reference model predicts
// each predictor write; a negedge monitor pops and compares.
module tb_bp_update_sched;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TAG_W    = 8;
  localparam logic [1:0]  INIT_VAL = 2'b11;
  localparam int unsigned NIDX     = 1 << TAG_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             mode;
    logic             jr;
    logic [1:0]       val;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  bp_update_sched_if #(.TAG_W(TAG_W)) bus ();

  bp_update_sched #(
    .DEPTH    (DEPTH),
    .TAG_W    (TAG_W),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks      = 0;
  int passes      = 0;
  int model_drops = 0;
  int drops_seen  = 0;
  int sidx        = 0;
  int busy_cnt    = 0;
  bit sweeping    = 1'b0;
  bit started     = 1'b0;

  wr_t            exp_q[$];
  logic [TAG_W:0] mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the update queue, a sweep counter and a sweeping flag.
  task automatic model_edge();
    bit full_pre;
    logic [TAG_W:0] e;
    if (rst) begin
      mq.delete();
      sweeping = 1'b0;
      sidx     = 0;
      return;
    end
    if (!rdy) return;
    full_pre = (mq.size() == DEPTH);
    if (bus.in_rob_valid && full_pre) model_drops++;
    if (sweeping) begin
      exp_q.push_back('{tag: TAG_W'(sidx), mode: 1'b1, jr: 1'b0, val: INIT_VAL});
      sidx++;
      if (sidx == NIDX) sweeping = 1'b0;
      if (bus.in_rob_valid && !full_pre) mq.push_back({bus.in_rob_tag, bus.in_rob_jump_res});
    end else if (bus.in_clear_req) begin
      mq.delete();
      sweeping = 1'b1;
      sidx     = 0;
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        exp_q.push_back('{tag: e[TAG_W:1], mode: 1'b0, jr: e[0], val: 2'b00});
      end
      if (bus.in_rob_valid && !full_pre) mq.push_back({bus.in_rob_tag, bus.in_rob_jump_res});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input bit v, input logic [TAG_W-1:0] t,
                       input bit j, input bit c, input int n);
    rdy                 = r;
    bus.in_rob_valid    = v;
    bus.in_rob_tag      = t;
    bus.in_rob_jump_res = j;
    bus.in_clear_req    = c;
    repeat (n) tick();
  endtask

  always @(posedge clk) begin
    if (rst === 1'b0 && rdy === 1'b1 && bus.in_rob_valid === 1'b1 && bus.out_rob_full === 1'b1) begin
      drops_seen++;
      $display("note: push while full dropped at %0t", $time);
    end
  end

  always @(negedge clk) begin : monitor
    wr_t e;
    if (started) begin
      chk("busy", 32'(bus.out_clear_busy), 32'(sweeping));
      chk("rob_full", 32'(bus.out_rob_full), 32'(mq.size() == DEPTH));
      if (exp_q.size() == 0) begin
        chk("no_write", 32'(bus.out_bp_valid), 32'(1'b0));
      end else begin
        e = exp_q.pop_front();
        chk("write_valid", 32'(bus.out_bp_valid), 32'(1'b1));
        if (bus.out_bp_valid === 1'b1) begin
          chk("wr_tag", 32'(bus.out_bp_tag), 32'(e.tag));
          chk("wr_mode", 32'(bus.out_bp_mode), 32'(e.mode));
          if (e.mode) chk("wr_val", 32'(bus.out_bp_val), 32'(e.val));
          else        chk("wr_jump_res", 32'(bus.out_bp_jump_res), 32'(e.jr));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2);
    chk("rst_valid", 32'(bus.out_bp_valid), 32'(0));
    chk("rst_tag", 32'(bus.out_bp_tag), 32'(0));
    chk("rst_mode", 32'(bus.out_bp_mode), 32'(0));
    chk("rst_jump_res", 32'(bus.out_bp_jump_res), 32'(0));
    chk("rst_val", 32'(bus.out_bp_val), 32'(0));
    chk("rst_busy", 32'(bus.out_clear_busy), 32'(0));
    chk("rst_full", 32'(bus.out_rob_full), 32'(0));
    rst = 1'b0;

    // Two commits, then drain.
    drive(1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 3);

    // Sweep blocks pops: fill to full, drop the 5th, ignore a second clear.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1);
    drive(1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 1);
    chk("drop_on_full", 32'(drops_seen), 32'(1));
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, NIDX - 5);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 5);
    chk("hold_full", 32'(bus.out_rob_full), 32'(1));
    chk("hold_count", 32'(dut.u_fifo.cnt), 32'(4));
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 6);

    // Clear with three entries queued (plus a same-cycle push): all flushed.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    drive(1'b1, 1'b1, 8'h51, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h52, 1'b0, 1'b0, 1);
    drive(1'b1, 1'b1, 8'h53, 1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, NIDX - 3);
    chk("queued_before_clear", 32'(dut.u_fifo.cnt), 32'(3));
    busy_cnt = 0;
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1);
    if (bus.out_clear_busy === 1'b1) busy_cnt++;
    for (int i = 0; i < 259; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
      if (bus.out_clear_busy === 1'b1) busy_cnt++;
    end
    chk("busy_cycles", 32'(busy_cnt), 32'(NIDX));

    // Reset aborts a sweep at index 100.
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 1);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 100);
    rst = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1);
    chk("abort_valid", 32'(bus.out_bp_valid), 32'(0));
    chk("abort_busy", 32'(bus.out_clear_busy), 32'(0));
    chk("abort_count", 32'(dut.u_fifo.cnt), 32'(0));
    rst = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 5);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 6, TAG_W'($urandom),
            1'($urandom), $urandom_range(0, 199) == 0, 1);
    end
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, NIDX + DEPTH + 4);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    chk("drop_count", 32'(drops_seen), 32'(model_drops));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
